// File: rtl/spi_master.sv
// SPI mode-0 master: 8-bit MSB-first frames, cs_n framing, one-cycle done pulse.
// Each of the LEAD/LOW/HIGH/TRAIL phases lasts CLK_DIV clk cycles.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       spi_clk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LEAD, LOW, HIGH, TRAIL} state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic [2:0]       bit_cnt, bit_d;
  logic [7:0]       tx_shift, tx_d;
  logic [7:0]       rx_shift, rx_d;
  logic             spi_clk_d, mosi_d, cs_n_d, busy_d, done_d;
  logic [7:0]       rx_data_d;
  logic             phase_end;

  assign phase_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      spi_clk  <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_d;
      bit_cnt  <= bit_d;
      tx_shift <= tx_d;
      rx_shift <= rx_d;
      spi_clk  <= spi_clk_d;
      mosi     <= mosi_d;
      cs_n     <= cs_n_d;
      busy     <= busy_d;
      done     <= done_d;
      rx_data  <= rx_data_d;
    end
  end

  always_comb begin
    state_d   = state;
    div_d     = div_cnt;
    bit_d     = bit_cnt;
    tx_d      = tx_shift;
    rx_d      = rx_shift;
    spi_clk_d = spi_clk;
    mosi_d    = mosi;
    cs_n_d    = cs_n;
    busy_d    = busy;
    done_d    = 1'b0;
    rx_data_d = rx_data;

    if (state != IDLE) begin
      div_d = phase_end ? '0 : div_cnt + DIV_W'(1);
    end

    case (state)
      IDLE: begin
        if (start) begin
          tx_d    = tx_data;
          mosi_d  = tx_data[7];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          div_d   = '0;
          state_d = LEAD;
        end
      end
      LEAD, LOW: begin
        if (phase_end) begin
          spi_clk_d = 1'b1;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        // Sample at the end of the high phase to tolerate slave-side latency.
        if (phase_end) begin
          rx_d      = {rx_shift[6:0], miso};
          spi_clk_d = 1'b0;
          if (bit_cnt != 3'd7) begin
            bit_d   = bit_cnt + 3'd1;
            tx_d    = {tx_shift[6:0], 1'b0};
            mosi_d  = tx_shift[6];
            state_d = LOW;
          end else begin
            mosi_d  = 1'b0;
            state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (phase_end) begin
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_shift;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, behavioural slave, back-to-back,
// mid-frame reset and CLK_DIV=2, with an expected-rx scoreboard.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  logic       a_start = 1'b0, b_start = 1'b0;
  logic [7:0] a_tx = '0, b_tx = '0;
  logic       a_busy, a_done, a_sck, a_mosi, a_miso, a_cs_n;
  logic       b_busy, b_done, b_sck, b_mosi, b_cs_n;
  logic [7:0] a_rx, b_rx;
  logic       a_loop = 1'b1;

  spi_master #(.CLK_DIV(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .tx_data(a_tx), .busy(a_busy),
    .done(a_done), .rx_data(a_rx), .spi_clk(a_sck), .mosi(a_mosi),
    .miso(a_miso), .cs_n(a_cs_n)
  );

  spi_master #(.CLK_DIV(2)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .tx_data(b_tx), .busy(b_busy),
    .done(b_done), .rx_data(b_rx), .spi_clk(b_sck), .mosi(b_mosi),
    .miso(b_mosi), .cs_n(b_cs_n)
  );

  // Behavioural mode-0 slave: samples mosi on rise, advances miso on fall.
  logic [7:0] sl_tx = 8'hD2;
  logic [7:0] sl_rx = '0;
  logic [3:0] sl_idx = '0;
  logic       sl_prev_cs = 1'b1, sl_prev_sck = 1'b0, sl_miso;
  always @(a_cs_n or a_sck) begin
    if (!a_cs_n && sl_prev_cs) begin
      sl_idx = '0;
      sl_rx  = '0;
    end else if (!a_cs_n && a_sck && !sl_prev_sck) begin
      sl_rx = {sl_rx[6:0], a_mosi};
    end else if (!a_cs_n && !a_sck && sl_prev_sck) begin
      sl_idx = sl_idx + 4'd1;
    end
    sl_prev_cs  = a_cs_n;
    sl_prev_sck = a_sck;
  end
  always_comb sl_miso = (sl_idx < 4'd8) ? sl_tx[3'(4'd7 - sl_idx)] : 1'b0;
  assign a_miso = a_loop ? a_mosi : sl_miso;

  // spi_clk rise monitors: rise cycle numbers and mosi value at each rise.
  int a_rises[$];
  int b_rises[$];
  logic [7:0] a_bits = '0, b_bits = '0;
  logic a_prev = 1'b0, b_prev = 1'b0;
  int a_done_cnt = 0;
  always @(negedge clk) begin
    if (a_sck && !a_prev) begin
      a_rises.push_back(cyc);
      a_bits = {a_bits[6:0], a_mosi};
    end
    if (b_sck && !b_prev) begin
      b_rises.push_back(cyc);
      b_bits = {b_bits[6:0], b_mosi};
    end
    a_prev = a_sck;
    b_prev = b_sck;
    if (a_done) a_done_cnt++;
  end

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input bit which, input logic [7:0] d, input bit hold, output int e0);
    @(negedge clk);
    if (which) begin b_rises.delete(); b_tx = d; b_start = 1'b1; end
    else begin a_rises.delete(); a_tx = d; a_start = 1'b1; end
    @(negedge clk);
    e0 = cyc;
    if (!hold) begin a_start = 1'b0; b_start = 1'b0; end
    chk("busy_on_accept", 32'(which ? b_busy : a_busy), 32'd1);
    chk("cs_low_on_accept", 32'(which ? b_cs_n : a_cs_n), 32'd0);
  endtask

  // Waits (bounded) for done, then checks latency, scoreboard rx, idle outputs, pulse width.
  task automatic wait_done(input bit which, input int e0, input int lat, input string tag,
                           output int dcyc);
    bit seen = 1'b0;
    logic [7:0] exp;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = which ? b_done : a_done;
    end
    dcyc = cyc;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (lat >= 0) chk({tag, "_latency"}, 32'(cyc - e0), 32'(lat));
      exp = which ? exp_b.pop_front() : exp_a.pop_front();
      chk({tag, "_rx_data"}, 32'(which ? b_rx : a_rx), 32'(exp));
      chk({tag, "_busy_low"}, 32'(which ? b_busy : a_busy), 32'd0);
      chk({tag, "_cs_high"}, 32'(which ? b_cs_n : a_cs_n), 32'd1);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(which ? b_done : a_done), 32'd0);
    end
  endtask

  initial begin
    int e0, d1, d2, cnt0;
    bit got;

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("rst_spi_clk", 32'(a_sck), 32'd0);
    chk("rst_mosi", 32'(a_mosi), 32'd0);
    chk("rst_cs_n", 32'(a_cs_n), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_rx_data", 32'(a_rx), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Loopback 0xCB.
    a_loop = 1'b1;
    exp_a.push_back(8'hCB);
    kick(1'b0, 8'hCB, 1'b0, e0);
    wait_done(1'b0, e0, 68, "loop_cb", d1);
    chk("loop_cb_rises", 32'(a_rises.size()), 32'd8);
    if (a_rises.size() == 8) begin
      chk("loop_cb_first_rise", 32'(a_rises[0] - e0), 32'd4);
      chk("loop_cb_second_rise", 32'(a_rises[1] - e0), 32'd12);
      chk("loop_cb_last_rise", 32'(a_rises[7] - e0), 32'd60);
    end
    chk("loop_cb_mosi_seq", 32'(a_bits), 32'hCB);

    // Against the behavioural slave.
    a_loop = 1'b0;
    exp_a.push_back(8'hD2);
    kick(1'b0, 8'hF0, 1'b0, e0);
    wait_done(1'b0, e0, 68, "slave_f0", d1);
    chk("slave_rx_f0", 32'(sl_rx), 32'hF0);
    exp_a.push_back(8'hD2);
    kick(1'b0, 8'hAB, 1'b0, e0);
    wait_done(1'b0, e0, 68, "slave_ab", d1);
    chk("slave_rx_ab", 32'(sl_rx), 32'hAB);

    // start held for two frames; tx_data changed mid-frame; start pulse during busy ignored.
    a_loop = 1'b1;
    cnt0 = a_done_cnt;
    exp_a.push_back(8'h0A);
    exp_a.push_back(8'h55);
    kick(1'b0, 8'h0A, 1'b1, e0);
    repeat (20) @(negedge clk);
    a_tx = 8'h55;
    wait_done(1'b0, e0, 68, "hold1", d1);
    chk("hold1_mosi_seq", 32'(a_bits), 32'h0A);
    chk("hold2_accepted", 32'(a_busy), 32'd1);
    a_start = 1'b0;
    repeat (20) @(negedge clk);
    a_tx = 8'hEE;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_done(1'b0, 0, -1, "hold2", d2);
    chk("hold_done_spacing", 32'(d2 - d1), 32'd69);
    repeat (150) @(negedge clk);
    chk("hold_done_count", 32'(a_done_cnt - cnt0), 32'd2);

    // Reset after the third spi_clk rise aborts the frame.
    kick(1'b0, 8'h3C, 1'b0, e0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (a_rises.size() >= 3);
    end
    chk("abort_third_rise_seen", 32'(got), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_spi_clk", 32'(a_sck), 32'd0);
    chk("abort_cs_n", 32'(a_cs_n), 32'd1);
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_mosi", 32'(a_mosi), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt0 = a_done_cnt;
    repeat (100) @(negedge clk);
    chk("abort_no_done", 32'(a_done_cnt - cnt0), 32'd0);
    exp_a.push_back(8'h0F);
    kick(1'b0, 8'h0F, 1'b0, e0);
    wait_done(1'b0, e0, 68, "after_abort", d1);

    // CLK_DIV=2 loopback.
    exp_b.push_back(8'h81);
    kick(1'b1, 8'h81, 1'b0, e0);
    wait_done(1'b1, e0, 34, "div2", d1);
    chk("div2_rises", 32'(b_rises.size()), 32'd8);
    if (b_rises.size() == 8) begin
      chk("div2_first_rise", 32'(b_rises[0] - e0), 32'd2);
      chk("div2_rise_period", 32'(b_rises[1] - b_rises[0]), 32'd4);
      chk("div2_last_rise", 32'(b_rises[7] - e0), 32'd30);
    end
    chk("div2_mosi_seq", 32'(b_bits), 32'h81);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
